// File: rtl/pwm.sv
// Fixed-frequency PWM with a 2^WIDTH-clock period. The duty word is shadowed
// at the period boundary so the output never changes shape mid-period.
module pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic             pout,
  output logic             pstart
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic             wrap;

  assign wrap = (cnt == MAX);

  // cnt resets to MAX so the first post-reset edge loads the duty word and
  // the first real period starts one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= MAX;
      duty_q <= '0;
      pout   <= 1'b0;
      pstart <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      if (wrap) duty_q <= pin;
      pout   <= (cnt < duty_q);
      pstart <= (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: table of whole periods (duty load, optional mid-period
// pin change, expected high count) plus reset-sequence corner cases.
module tb_pwm;

  localparam int WIDTH = 8;
  localparam int PER   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pin;
  logic             pout;
  logic             pstart;

  int checks   = 0;
  int failures = 0;

  pwm #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .pin   (pin),
    .pout  (pout),
    .pstart(pstart)
  );

  always #5 clk = ~clk;

  typedef struct {
    int setpin;   // pin driven at period start (loaded at this period's end)
    int chg_at;   // sample index at which pin changes, -1 for none
    int chg_val;
    int exp_high; // expected high clocks in this period
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called with the period-start sample visible; returns at the next one.
  task automatic run_period(input string name, input int exp_high,
                            input int chg_at, input int chg_val);
    int hi = 0, perr = 0, serr = 0;
    for (int i = 0; i < PER; i++) begin
      if (pout) hi++;
      if (pout != (i < exp_high)) perr++;
      if (pstart != (i == 0)) serr++;
      if (i == chg_at) pin = chg_val[WIDTH-1:0];
      step();
    end
    chk({name, " high_count"}, hi, exp_high);
    chk({name, " shape_errs"}, perr, 0);
    chk({name, " pstart_errs"}, serr, 0);
  endtask

  initial begin
    vec[0] = '{128, -1,  0, 0};
    vec[1] = '{128, 10, 64, 0};
    vec[2] = '{  0, -1,  0, 0};
    vec[3] = '{255, -1,  0, 0};
    vec[4] = '{  1, -1,  0, 0};
    vec[5] = '{ 37,100, 90, 0};
    for (int k = 6; k < NV - 1; k++) begin
      vec[k].setpin  = int'($urandom_range(0, PER - 1));
      vec[k].chg_at  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, PER - 3)) : -1;
      vec[k].chg_val = int'($urandom_range(0, PER - 1));
      vec[k].exp_high = 0;
    end
    vec[NV-1] = '{200, -1, 0, 0};
    vec[0].exp_high = 128;
    for (int k = 1; k < NV; k++)
      vec[k].exp_high = (vec[k-1].chg_at >= 0) ? vec[k-1].chg_val : vec[k-1].setpin;

    // Reset with pin=128, then the edge-1 / edge-2 start-up sequence
    rst = 1'b1;
    pin = 8'd128;
    step();
    step();
    chk("reset pout", int'(pout), 0);
    chk("reset pstart", int'(pstart), 0);
    rst = 1'b0;
    step();
    chk("edge1 pout", int'(pout), 0);
    chk("edge1 pstart", int'(pstart), 0);
    step();
    chk("edge2 pout", int'(pout), 1);
    chk("edge2 pstart", int'(pstart), 1);

    for (int k = 0; k < NV; k++) begin
      pin = vec[k].setpin[WIDTH-1:0];
      run_period($sformatf("vec%0d", k), vec[k].exp_high, vec[k].chg_at, vec[k].chg_val);
    end

    // Reset mid-high-phase of a 200-duty period at cnt=50
    for (int i = 0; i < 50; i++) step();
    chk("mid pout before reset", int'(pout), 1);
    rst = 1'b1;
    step();
    chk("mid reset pout", int'(pout), 0);
    chk("mid reset pstart", int'(pstart), 0);
    rst = 1'b0;
    step();
    chk("mid edge1 pout", int'(pout), 0);
    chk("mid edge1 pstart", int'(pstart), 0);
    step();
    chk("mid edge2 pout", int'(pout), 1);
    chk("mid edge2 pstart", int'(pstart), 1);
    run_period("after mid reset", 200, -1, 0);

    // pin=0 from reset: output never rises, pstart still pulses
    rst = 1'b1;
    pin = '0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("zero edge2 pout", int'(pout), 0);
    chk("zero edge2 pstart", int'(pstart), 1);
    run_period("zero p0", 0, -1, 0);
    run_period("zero p1", 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
